button_press_counter: RTL
=========================

Name: button_press_counter

Overview:
- Clocked front end for the pmod push-buttons: synchronises, debounces and edge-detects two raw active-low buttons.
- Converts each press into a single-cycle pulse and drives a free-running LED counter from those pulses on the system clock.
- Buttons act only as inputs; they are never used as clock or reset.
- Sits between the pmod pins and the LED bank.

Parameters:
- DEBOUNCE_CYCLES, 120000, consecutive stable clk cycles required to accept a level change (10 ms at 12 MHz); minimum 2.
- LED_W, 4, counter / LED width.
- REPEAT_CYCLES, 6000000, hold interval between auto-repeat increments (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset; all state cleared while low.
- pmod  input  2  raw buttons, active-low, asynchronous to clk; [0] = clear, [1] = increment.
- led  output  LED_W  counter value.
- btn_level  output  2  debounced pressed level, active-high.
- btn_pulse  output  2  one-cycle press strobe per button.

Behaviour:
- Reset (rst low): led=0, btn_level=0, btn_pulse=0, synchronisers preset to released (1), debounce counters=0, all FSMs in IDLE. Release of rst takes effect on the next clk edge.
- Synchroniser: two flops per bit on pmod; the stage-2 output is inverted to form an active-high pressed signal.
- Per-button FSM, states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - IDLE: synced pressed=1 -> PRESS_WAIT, counter cleared.
  - PRESS_WAIT: pressed=0 -> IDLE (bounce). Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1 -> PRESSED, btn_level=1, btn_pulse high for exactly one cycle.
  - PRESSED: pressed=0 -> RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: pressed=1 -> PRESSED (bounce, no new pulse). Counter reaching DEBOUNCE_CYCLES-1 -> IDLE, btn_level=0.
- Latency: clean raw press -> btn_pulse asserted DEBOUNCE_CYCLES+2 edges later -> led updated on the following edge.
- Counter:
  - btn_pulse[0] -> led=0.
  - btn_pulse[1] -> led=led+1, modulo 2^LED_W; all-ones wraps to 0.
  - Simultaneous pulses: clear wins, led=0.
- A press held indefinitely produces exactly one pulse. Release bounces shorter than DEBOUNCE_CYCLES produce no pulse.
- rst asserted mid-debounce or mid-hold: the FSM returns to IDLE immediately with no pulse. A button still held at rst release is treated as a new press and pulses after the full debounce.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined: while button[1] stays in PRESSED, a repeat counter re-asserts btn_pulse[1] every REPEAT_CYCLES cycles after the initial pulse. The repeat counter clears on leaving PRESSED and on reset. Button[0] never repeats.
- Undefined: the repeat counter and its logic are absent; one pulse per press.

Decomposition:
- Package button_pkg:
  - FSM state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT).
  - Button index constants BTN_CLR=0, BTN_INC=1.
  - Debounce counter width function (clog2 of DEBOUNCE_CYCLES).
- Sub-module btn_debounce: one instance per button; contains the synchroniser, FSM, counter and pulse logic, with outputs level and pulse.
- Top level: the LED counter plus the two instances.

Test Plan (simulate with DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32):
- Reset with pmod=2'b11 -> led=0, btn_level=0, btn_pulse=0. Hold rst low for 3 cycles, then release -> all outputs stay 0.
- Clean press of pmod[1] for 20 cycles -> one btn_pulse[1] 10 edges after the raw edge; led 0->1 on the following edge; release leaves led=1.
- Press pmod[1] with 3-cycle bounces at both press and release, then a clean hold -> exactly one pulse, led=1.
- 16 clean increment presses -> led counts through 15, then wraps to 0.
- led=5, both buttons pressed on the same edge -> pulses coincide, led=0.
- rst pulled low 4 cycles into PRESS_WAIT -> no pulse, led=0. Button held through rst release -> pulse 10 edges after release, led=1.
- With BUTTON_AUTO_REPEAT_EN defined, hold pmod[1] for 100 cycles after first pulse -> 3 extra pulses 32 cycles apart, led=4.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button front end.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int BTN_CLR = 0;
    localparam int BTN_INC = 1;

    // Width able to hold cycles-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, debounce FSM, level and one-cycle press pulse.
// Auto-repeat on held press is built only when BUTTON_AUTO_REPEAT_EN is defined.
module btn_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000
`ifdef BUTTON_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = 6000000,
    parameter bit REPEAT_EN       = 1'b0
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2, pressed;
    btn_state_e    state, state_next;
    logic [CW-1:0] cnt, cnt_next, cnt_inc;
    logic          level_next, pulse_next;

    // Synchronisers preset to "released" so reset never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign pressed = ~sync2;
    assign cnt_inc = cnt + 1'b1;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int            RW       = cnt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_DONE = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep, rep_next;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = level;
        pulse_next = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
        rep_next   = '0;
`endif
        case (state)
            IDLE: begin
                if (pressed) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_next = IDLE;
                end else if (cnt_inc == CNT_DONE) begin
                    state_next = PRESSED;
                    level_next = 1'b1;
                    pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
`ifdef BUTTON_AUTO_REPEAT_EN
                else if (REPEAT_EN) begin
                    if (rep == REP_DONE) begin
                        pulse_next = 1'b1;
                    end else begin
                        rep_next = rep + 1'b1;
                    end
                end
`endif
            end
            RELEASE_WAIT: begin
                // Bouncing back to pressed resumes the hold without a new pulse.
                if (pressed) begin
                    state_next = PRESSED;
                end else if (cnt_inc == CNT_DONE) begin
                    state_next = IDLE;
                    level_next = 1'b0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                level_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
            pulse <= pulse_next;
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep <= '0;
        end else begin
            rep <= rep_next;
        end
    end
`endif

endmodule

// File: rtl/button_press_counter.sv
// Pmod push-button front end driving a LED counter: [0] clears, [1] increments.
// BUTTON_AUTO_REPEAT_EN adds auto-repeat on a held increment button.
module button_press_counter
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LED_W           = 4,
    parameter int REPEAT_CYCLES   = 6000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       pmod,
    output logic [LED_W-1:0] led,
    output logic [1:0]       btn_level,
    output logic [1:0]       btn_pulse
);

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BUTTON_AUTO_REPEAT_EN
        ,
        .REPEAT_CYCLES  (REPEAT_CYCLES),
        .REPEAT_EN      (1'b0)
`endif
    ) u_clr (
        .clk  (clk),
        .rst  (rst),
        .raw  (pmod[BTN_CLR]),
        .level(btn_level[BTN_CLR]),
        .pulse(btn_pulse[BTN_CLR])
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BUTTON_AUTO_REPEAT_EN
        ,
        .REPEAT_CYCLES  (REPEAT_CYCLES),
        .REPEAT_EN      (1'b1)
`endif
    ) u_inc (
        .clk  (clk),
        .rst  (rst),
        .raw  (pmod[BTN_INC]),
        .level(btn_level[BTN_INC]),
        .pulse(btn_pulse[BTN_INC])
    );

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led <= '0;
        end else if (btn_pulse[BTN_CLR]) begin
            led <= '0;
        end else if (btn_pulse[BTN_INC]) begin
            led <= led + 1'b1;
        end
    end

endmodule
